// File: rtl/mmr_pkg.sv
// ============================================================================
// Module  : mmr_pkg
// Purpose : Shared types and default widths for the MMR access controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mmr_pkg;

    localparam int          MMR_ADDR_W   = 8;
    localparam int          MMR_DATA_W   = 32;
    localparam int          MMR_TIMEOUT  = 16;
    localparam logic [31:0] MMR_ERR_DATA = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Index (0/1) of a one-hot two-bit grant vector.
    function automatic logic grant_index(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage : mmr_pkg

`default_nettype wire

// File: rtl/mmr_access_ctrl_if.sv
// ============================================================================
// Module  : mmr_access_ctrl_if
// Purpose : CPU-side request ports and peripheral register bus of the MMR controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmr_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);

    logic              EnableMmr0;
    logic [ADDR_W-1:0] AddrMmr0;
    logic              WrEn0;
    logic [DATA_W-1:0] WrData0;
    logic              EnableMmr1;
    logic [ADDR_W-1:0] AddrMmr1;
    logic              WrEn1;
    logic [DATA_W-1:0] WrData1;

    logic              Rda0;
    logic              Rda1;
    logic [DATA_W-1:0] RData0;
    logic [DATA_W-1:0] RData1;
    logic              Err0;
    logic              Err1;

    logic              PeriphSel;
    logic [ADDR_W-1:0] PeriphAddr;
    logic              PeriphWr;
    logic [DATA_W-1:0] PeriphWData;
    logic [DATA_W-1:0] PeriphRData;
    logic              PeriphAck;

    // Environment side: issues CPU requests and models the peripheral.
    modport master (
        output EnableMmr0, AddrMmr0, WrEn0, WrData0,
        output EnableMmr1, AddrMmr1, WrEn1, WrData1,
        input  Rda0, Rda1, RData0, RData1, Err0, Err1,
        input  PeriphSel, PeriphAddr, PeriphWr, PeriphWData,
        output PeriphRData, PeriphAck
    );

    // Controller side.
    modport slave (
        input  EnableMmr0, AddrMmr0, WrEn0, WrData0,
        input  EnableMmr1, AddrMmr1, WrEn1, WrData1,
        output Rda0, Rda1, RData0, RData1, Err0, Err1,
        output PeriphSel, PeriphAddr, PeriphWr, PeriphWData,
        input  PeriphRData, PeriphAck
    );

endinterface : mmr_access_ctrl_if

`default_nettype wire

// File: rtl/mmr_rr_arbiter.sv
// ============================================================================
// Module  : mmr_rr_arbiter
// Purpose : Two-way combinational round-robin arbiter (one-hot grant).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mmr_rr_arbiter (
    input  wire logic [1:0] req,
    input  wire logic       last_grant,
    output logic      [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the port that was not served last time wins.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule : mmr_rr_arbiter

`default_nettype wire

// File: rtl/mmr_access_ctrl.sv
// ============================================================================
// Module  : mmr_access_ctrl
// Purpose : Arbitrates two CPU MMR ports onto one peripheral register bus with timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mmr_access_ctrl
    import mmr_pkg::*;
#(
    parameter int                ADDR_W   = MMR_ADDR_W,
    parameter int                DATA_W   = MMR_DATA_W,
    parameter int                TIMEOUT  = MMR_TIMEOUT,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(MMR_ERR_DATA)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mmr_access_ctrl_if.slave  bus
);

    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_err0;
    logic                r_err1;

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic                w_gnt_idx;
    logic                w_start;
    logic                w_finish;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_result;

    assign w_req     = {bus.EnableMmr1, bus.EnableMmr0};
    assign w_gnt_idx = grant_index(w_grant);

    mmr_rr_arbiter u_arbiter (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (bus.PeriphAck) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_finish    = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_result = bus.PeriphRData;
        if (w_timeout) begin
            w_result = ERR_DATA;
        end else if (r_wr) begin
            w_result = '0;
        end
    end

    // Bus request registers and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wr         <= 1'b0;
            r_wdata      <= '0;
        end else if (w_start) begin
            r_last_grant <= w_gnt_idx;
            r_cnt        <= '0;
            r_addr       <= w_gnt_idx ? bus.AddrMmr1 : bus.AddrMmr0;
            r_wr         <= w_gnt_idx ? bus.WrEn1    : bus.WrEn0;
            r_wdata      <= w_gnt_idx ? bus.WrData1  : bus.WrData0;
        end else if ((r_state == ST_ACCESS) && !w_finish) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Per-port response registers keep their value between completions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else if (w_finish) begin
            if (r_last_grant) begin
                r_rdata1 <= w_result;
                r_err1   <= w_timeout;
            end else begin
                r_rdata0 <= w_result;
                r_err0   <= w_timeout;
            end
        end
    end

    assign bus.PeriphSel   = (r_state == ST_ACCESS);
    assign bus.PeriphAddr  = r_addr;
    assign bus.PeriphWr    = r_wr;
    assign bus.PeriphWData = r_wdata;

    assign bus.Rda0   = (r_state == ST_RESP) && !r_last_grant;
    assign bus.Rda1   = (r_state == ST_RESP) &&  r_last_grant;
    assign bus.RData0 = r_rdata0;
    assign bus.RData1 = r_rdata1;
    assign bus.Err0   = r_err0;
    assign bus.Err1   = r_err1;

endmodule : mmr_access_ctrl

`default_nettype wire

// File: tb/tb_mmr_access_ctrl.sv
// ============================================================================
// Module  : tb_mmr_access_ctrl
// Purpose : Self-checking bench for mmr_access_ctrl against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmr_access_ctrl;

    localparam int          TO    = 16;
    localparam logic [31:0] ERR_D = 32'hBADC0DE5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mmr_access_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    mmr_access_ctrl #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .TIMEOUT  (TO),
        .ERR_DATA (ERR_D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit rand_en = 1'b0;

    // Requester side: a held request and what the peripheral will answer it with.
    bit          pend    [2];
    logic [7:0]  q_addr  [2];
    bit          q_wr    [2];
    logic [31:0] q_wdata [2];
    logic [31:0] q_rd    [2];
    int          q_d     [2];

    // Transaction model: one access in flight, granted in cycle g, completes in done_c.
    bit          busy;
    int          g, done_c, port, m_d;
    logic [7:0]  m_addr;
    bit          m_wr, m_err, last;
    logic [31:0] m_wdata, m_rd, m_res;
    logic [31:0] last_rdata [2];
    bit          last_err   [2];

    bit          seen       [2];
    int          seen_c     [2];
    logic [31:0] seen_rdata [2];
    bit          seen_err   [2];
    int          last_sel_c;
    logic [31:0] seen_wdata;
    bit          seen_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        busy = 0; last = 1;
        for (int p = 0; p < 2; p++) begin
            last_rdata[p] = '0; last_err[p] = 0; pend[p] = 0;
        end
    endtask

    task automatic check_outputs();
        bit          sel_e, rda_e;
        logic        rda_a [2];
        logic [31:0] rd_a  [2];
        logic        er_a  [2];
        rda_a[0] = bus.Rda0;   rda_a[1] = bus.Rda1;
        rd_a[0]  = bus.RData0; rd_a[1]  = bus.RData1;
        er_a[0]  = bus.Err0;   er_a[1]  = bus.Err1;
        sel_e = busy && (cyc > g) && (cyc < done_c);
        chk("PeriphSel", bus.PeriphSel, sel_e);
        if (sel_e) begin
            chk("PeriphAddr", bus.PeriphAddr, m_addr);
            chk("PeriphWr", bus.PeriphWr, m_wr);
            chk("PeriphWData", bus.PeriphWData, m_wdata);
            last_sel_c = cyc; seen_wdata = bus.PeriphWData; seen_wr = bus.PeriphWr;
        end
        for (int p = 0; p < 2; p++) begin
            rda_e = busy && (cyc == done_c) && (port == p);
            chk($sformatf("Rda%0d", p), rda_a[p], rda_e);
            chk($sformatf("RData%0d", p), rd_a[p], rda_e ? m_res : last_rdata[p]);
            chk($sformatf("Err%0d", p), er_a[p], rda_e ? m_err : last_err[p]);
            if (rda_a[p] === 1'b1) begin
                seen[p] = 1; seen_c[p] = cyc; seen_rdata[p] = rd_a[p]; seen_err[p] = er_a[p];
            end
        end
    endtask

    task automatic drive_inputs();
        bit cleared [2];
        cleared[0] = 0; cleared[1] = 0;
        if (busy && cyc == done_c) begin
            pend[port] = 0; cleared[port] = 1;
        end
        if (rand_en) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && !cleared[p] && $urandom_range(3) == 0) begin
                    pend[p] = 1; q_addr[p] = 8'($urandom); q_wr[p] = 1'($urandom_range(1));
                    q_wdata[p] = $urandom; q_rd[p] = $urandom;
                    q_d[p] = ($urandom_range(4) == 0) ? int'($urandom_range(TO + 2, TO - 2))
                                                      : int'($urandom_range(3));
                end
            end
        end
        bus.EnableMmr0 = pend[0]; bus.AddrMmr0 = q_addr[0]; bus.WrEn0 = q_wr[0]; bus.WrData0 = q_wdata[0];
        bus.EnableMmr1 = pend[1]; bus.AddrMmr1 = q_addr[1]; bus.WrEn1 = q_wr[1]; bus.WrData1 = q_wdata[1];
        if (busy && cyc > g && cyc < done_c) begin
            bus.PeriphAck   = (m_d < TO) && (cyc == g + 1 + m_d);
            bus.PeriphRData = bus.PeriphAck ? m_rd : $urandom;
        end else begin
            // Outside an access the ack line is noise the controller must ignore.
            bus.PeriphAck   = 1'($urandom_range(1));
            bus.PeriphRData = $urandom;
        end
    endtask

    task automatic model_update();
        if (!busy) begin
            if (pend[0] || pend[1]) begin
                port    = (pend[0] && pend[1]) ? (last ? 0 : 1) : (pend[0] ? 0 : 1);
                busy    = 1; g = cyc; last = 1'(port);
                m_addr  = q_addr[port]; m_wr = q_wr[port]; m_wdata = q_wdata[port];
                m_d     = q_d[port]; m_rd = q_rd[port];
                m_err   = (m_d > TO - 1);
                done_c  = g + 2 + (m_err ? TO - 1 : m_d);
                m_res   = m_err ? ERR_D : (m_wr ? 32'h0 : m_rd);
            end
        end else if (cyc == done_c) begin
            last_rdata[port] = m_res; last_err[port] = m_err; busy = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_outputs();
        drive_inputs();
        model_update();
    endtask

    task automatic req(input int p, input logic [7:0] a, input bit wr, input logic [31:0] wd,
                       input int d, input logic [31:0] rd);
        pend[p] = 1; q_addr[p] = a; q_wr[p] = wr; q_wdata[p] = wd; q_d[p] = d; q_rd[p] = rd;
        seen[p] = 0;
    endtask

    task automatic run_until(input int p, output int c);
        for (int i = 0; i < 60 && !seen[p]; i++) step();
        chk($sformatf("rda%0d_arrived", p), seen[p], 1);
        c = seen_c[p];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t, t0, t1, t0b;
        model_reset();
        q_addr = '{8'h0, 8'h0}; q_wr = '{0, 0}; q_wdata = '{0, 0}; q_rd = '{0, 0}; q_d = '{0, 0};
        g = 0; done_c = 0; port = 0;
        bus.EnableMmr0 = 0; bus.AddrMmr0 = '0; bus.WrEn0 = 0; bus.WrData0 = '0;
        bus.EnableMmr1 = 0; bus.AddrMmr1 = '0; bus.WrEn1 = 0; bus.WrData1 = '0;
        bus.PeriphAck = 0; bus.PeriphRData = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("reset_sel", bus.PeriphSel, 0);
        chk("reset_rda", {bus.Rda1, bus.Rda0}, 0);
        chk("reset_rdata0", bus.RData0, 0);
        chk("reset_err", {bus.Err1, bus.Err0}, 0);
        chk("reset_addr", bus.PeriphAddr, 0);

        // Simultaneous requests after reset, then port 0 re-requests against waiting port 1.
        req(0, 8'h01, 0, 0, 0, 32'h11110000);
        req(1, 8'h02, 0, 0, 0, 32'h22220000);
        step();
        run_until(0, t0);
        chk("t2_p1_not_first", seen[1], 0);
        req(0, 8'h03, 0, 0, 0, 32'h33330000);
        run_until(1, t1);
        run_until(0, t0b);
        chk("t2_p0_before_p1", t0 < t1, 1);
        chk("t2_p1_before_p0_again", t1 < t0b, 1);
        repeat (2) step();

        req(0, 8'h10, 0, 0, 1, 32'h12345678);
        seen[1] = 0;
        step(); c = cyc;
        run_until(0, t);
        chk("t1_latency", t - c, 3);
        chk("t1_rdata", seen_rdata[0], 32'h12345678);
        chk("t1_no_rda1", seen[1], 0);
        repeat (2) step();

        req(1, 8'h04, 1, 32'hCAFEF00D, 0, 32'h55555555);
        seen_wr = 0;
        step(); c = cyc;
        run_until(1, t);
        chk("t3_latency", t - c, 2);
        chk("t3_err", seen_err[1], 0);
        chk("t3_wdata", seen_wdata, 32'hCAFEF00D);
        chk("t3_wr", seen_wr, 1);
        chk("t3_rdata_zero", seen_rdata[1], 0);
        repeat (2) step();

        req(0, 8'h20, 0, 0, 100, 32'h77777777);
        step(); c = cyc;
        run_until(0, t);
        chk("t4_latency", t - c, TO + 1);
        chk("t4_err", seen_err[0], 1);
        chk("t4_rdata", seen_rdata[0], ERR_D);
        chk("t4_last_sel", last_sel_c - c, TO);
        repeat (2) step();

        req(0, 8'h30, 0, 0, TO - 1, 32'h0BADF00D);
        step(); c = cyc;
        run_until(0, t);
        chk("t6_latency", t - c, TO + 1);
        chk("t6_err", seen_err[0], 0);
        chk("t6_rdata", seen_rdata[0], 32'h0BADF00D);
        repeat (2) step();

        // Asynchronous reset in the middle of an access.
        req(0, 8'h40, 0, 0, 100, 32'h0);
        repeat (3) step();
        chk("t5_sel_before", bus.PeriphSel, 1);
        pend[0] = 0; bus.EnableMmr0 = 0;
        #2 rst = 1;
        #1;
        chk("t5_sel_async", bus.PeriphSel, 0);
        chk("t5_no_rda", {bus.Rda1, bus.Rda0}, 0);
        @(negedge clk);
        cyc++;
        rst = 0;
        model_reset();
        seen[0] = 0;
        check_outputs(); drive_inputs(); model_update();
        repeat (20) step();
        chk("t5_no_rda_after", seen[0], 0);
        req(1, 8'h50, 0, 0, 2, 32'hA5A5A5A5);
        step(); c = cyc;
        run_until(1, t);
        chk("t5_p1_latency", t - c, 4);
        chk("t5_p1_rdata", seen_rdata[1], 32'hA5A5A5A5);

        rand_en = 1;
        repeat (3000) step();
        rand_en = 0;
        for (int i = 0; i < 200 && (busy || pend[0] || pend[1]); i++) step();
        chk("drain_idle", busy || pend[0] || pend[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mmr_access_ctrl

`default_nettype wire
